regfile_context_engine: RTL

Sequencer and write-port arbiter for the 8 x 16-bit LC-3 register file. On command it either saves R0..R7 to eight consecutive memory words or restores them from memory, driving the register file's SR1 read select and its write port (DR/LD_REG/BUS) itself. While idle it passes the core datapath's register-file controls straight through. It sits between the core control unit, the register file and the memory interface, and is used for context save/restore on traps and interrupts.

---
 rtl/regfile_context_engine.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/regfile_context_engine.sv
// regfile_context_engine
//
// Save/restore sequencer and write-port arbiter for the 8 x 16-bit LC-3
// register file. A save copies R0..R7 to eight consecutive memory words
// starting at Base. A restore loads R0..R7 from those words. While idle, the
// core's register-file controls pass straight through to the register file.
// While busy, the engine owns the register file and the core is stalled.
//
// Ports
//   Clk, Reset            clock, synchronous active-high reset
//   Start, Mode, Base     command strobe, 0=save / 1=restore, first address
//   Busy, Done            operation in progress, one-cycle completion pulse
//   Core_SR1/DR/LD_REG/BUS  core register-file controls (passed through when idle)
//   Core_Stall            core must hold its write while high
//   SR1, SR1OUT           register-file read select and read data
//   DR, LD_REG, BUS       register-file write port
//   Mem_Req/WE/Addr/WData memory request channel
//   Mem_Ack, Mem_RData    memory accept and read data
module regfile_context_engine (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Mode,
  input  logic [15:0] Base,
  output logic        Busy,
  output logic        Done,
  input  logic [2:0]  Core_SR1,
  input  logic [2:0]  Core_DR,
  input  logic        Core_LD_REG,
  input  logic [15:0] Core_BUS,
  output logic        Core_Stall,
  output logic [2:0]  SR1,
  input  logic [15:0] SR1OUT,
  output logic [2:0]  DR,
  output logic        LD_REG,
  output logic [15:0] BUS,
  output logic        Mem_Req,
  output logic        Mem_WE,
  output logic [15:0] Mem_Addr,
  output logic [15:0] Mem_WData,
  input  logic        Mem_Ack,
  input  logic [15:0] Mem_RData
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SAVE_REQ = 3'd1,
    RST_REQ  = 3'd2,
    RST_WR   = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  idx;
  logic [15:0] base_q;
  logic [15:0] hold;
  logic [15:0] addr;

  // Address wraps naturally at 16 bits.
  assign addr = base_q + {13'd0, idx};

  // Sequencer state, register index, captured base and restore data holding register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      idx    <= 3'd0;
      base_q <= 16'd0;
      hold   <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (Start) begin
            base_q <= Base;
            idx    <= 3'd0;
            state  <= Mode ? RST_REQ : SAVE_REQ;
          end
        end
        SAVE_REQ: begin
          if (Mem_Ack) begin
            if (idx == 3'd7) state <= DONE;
            else             idx   <= idx + 3'd1;
          end
        end
        RST_REQ: begin
          if (Mem_Ack) begin
            hold  <= Mem_RData;
            state <= RST_WR;
          end
        end
        RST_WR: begin
          if (idx == 3'd7) begin
            state <= DONE;
          end else begin
            idx   <= idx + 3'd1;
            state <= RST_REQ;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode: passthrough when idle; otherwise the engine drives the
  // register file and memory. The core write is dropped, not queued, while busy.
  always_comb begin
    Busy      = 1'b0;
    Done      = 1'b0;
    SR1       = Core_SR1;
    DR        = Core_DR;
    LD_REG    = Core_LD_REG;
    BUS       = Core_BUS;
    Mem_Req   = 1'b0;
    Mem_WE    = 1'b0;
    Mem_Addr  = 16'd0;
    Mem_WData = 16'd0;
    if (state != IDLE) begin
      Busy   = 1'b1;
      SR1    = idx;
      DR     = idx;
      LD_REG = 1'b0;
      BUS    = hold;
    end else begin
      Busy   = 1'b0;
    end
    case (state)
      SAVE_REQ: begin
        Mem_Req   = 1'b1;
        Mem_WE    = 1'b1;
        Mem_Addr  = addr;
        Mem_WData = SR1OUT;
      end
      RST_REQ: begin
        Mem_Req  = 1'b1;
        Mem_Addr = addr;
      end
      RST_WR:  LD_REG = 1'b1;
      DONE:    Done   = 1'b1;
      default: ;
    endcase
  end

  assign Core_Stall = Busy;

endmodule
